// File: rtl/game_timer.sv
// Programmable round/phase timer: RUN phases QUIET, PRE and DONE, in periodic or one-shot mode.
// Optional prescaler enabled by defining GAME_TIMER_PRESCALE_EN.
module game_timer #(
  parameter int WIDTH    = 4,
  parameter int PERIOD   = 10,
  parameter int PRE_LEN  = 2,
  parameter int DONE_LEN = 2,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             pre,
  output logic             done,
  output logic             busy,
  output logic             wrap,
  output logic [WIDTH-1:0] count
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0] MIN_P     = WIDTH'(PRE_LEN + DONE_LEN + 1);
  localparam logic [WIDTH-1:0] PHASE_LEN = WIDTH'(PRE_LEN + DONE_LEN);
  localparam logic [WIDTH-1:0] DONE_W    = WIDTH'(DONE_LEN);

  if (PRE_LEN + DONE_LEN + 1 > (2 ** WIDTH) - 1) begin : g_bad_phase_len
    $error("game_timer: PRE_LEN+DONE_LEN+1 does not fit in WIDTH bits");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("game_timer: PRESCALE must be at least 1");
  end

  // Zero selects the default period; anything too short for all phases is raised to MIN_P.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] req);
    logic [WIDTH-1:0] p;
    p = (req == '0) ? WIDTH'(PERIOD) : req;
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             mode_reg, mode_next;
  logic             step;

`ifdef GAME_TIMER_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc_reg, presc_next;

  always_comb begin
    presc_next = presc_reg;
    if (start) begin
      presc_next = '0;
    end else if (state_reg == RUN && en) begin
      presc_next = (presc_reg == PS_LAST) ? '0 : presc_reg + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) presc_reg <= '0;
    else     presc_reg <= presc_next;
  end

  assign step = en && (presc_reg == PS_LAST);
`else
  assign step = en;
`endif

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    period_next = period_reg;
    mode_next   = mode_reg;
    wrap        = 1'b0;
    if (start) begin
      // Restart wins over stepping, so a wrap due this cycle is dropped.
      state_next  = RUN;
      count_next  = '0;
      period_next = clamp_period(period);
      mode_next   = mode;
    end else if (state_reg == RUN && step) begin
      if (count_reg == period_reg - WIDTH'(1)) begin
        wrap       = 1'b1;
        count_next = '0;
        if (mode_reg) state_next = IDLE;
      end else begin
        count_next = count_reg + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= clamp_period('0);
      mode_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      period_reg <= period_next;
      mode_reg   <= mode_next;
    end
  end

  assign busy  = (state_reg == RUN);
  assign count = count_reg;
  assign pre   = busy && (count_reg >= period_reg - PHASE_LEN) && (count_reg < period_reg - DONE_W);
  assign done  = busy && (count_reg >= period_reg - DONE_W);

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: per-cycle vector table plus reset and prescaler sequences.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       rst, start, en, mode;
  logic [3:0] period;
  logic       pre, done, busy, wrap;
  logic [3:0] count;

  int n_compared   = 0;
  int n_mismatched = 0;

  game_timer dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .mode(mode), .period(period),
    .pre(pre), .done(done), .busy(busy), .wrap(wrap), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, e, m;
    logic [3:0] p;
    logic [3:0] c;
    logic       pr, dn, bz, wr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, e, m, input logic [3:0] p, input logic [3:0] c,
                     input logic pr, dn, bz, wr);
    vec_t v;
    v.s = s; v.e = e; v.m = m; v.p = p; v.c = c;
    v.pr = pr; v.dn = dn; v.bz = bz; v.wr = wr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int pr, input int dn,
                         input int bz, input int wr);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".pre"},   int'(pre),   pr);
    chk({tag, ".done"},  int'(done),  dn);
    chk({tag, ".busy"},  int'(busy),  bz);
    chk({tag, ".wrap"},  int'(wrap),  wr);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0; mode = 1'b0; period = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

`ifndef GAME_TIMER_PRESCALE_EN
    // Default period 10: pre at 6,7; done at 8,9.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) add(0, 1, 0, 0, 4'(c), c == 6 || c == 7, c >= 8, 1, c == 9);
    for (int c = 0; c < 7; c++)  add(0, 1, 0, 0, 4'(c), c == 6 || c == 7, c >= 8, 1, c == 9);
    repeat (3) add(0, 0, 0, 0, 7, 1, 0, 1, 0);
    for (int c = 7; c < 10; c++) add(0, 1, 0, 0, 4'(c), c == 6 || c == 7, c >= 8, 1, c == 9);
    for (int c = 0; c < 9; c++)  add(0, 1, 0, 0, 4'(c), c == 6 || c == 7, c >= 8, 1, c == 9);
    // Restart at the final count: no wrap, then P=6 (pre 2,3; done 4,5).
    add(1, 1, 0, 6, 9, 0, 1, 1, 0);
    for (int c = 0; c < 6; c++)  add(0, 1, 0, 0, 4'(c), c == 2 || c == 3, c >= 4, 1, c == 5);
    // One-shot P=12: pre 8,9; done 10,11; then idle.
    add(1, 1, 1, 12, 0, 0, 0, 1, 0);
    for (int c = 0; c < 12; c++) add(0, 1, 0, 0, 4'(c), c == 8 || c == 9, c >= 10, 1, c == 11);
    repeat (2) add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // Period 3 clamps to 5: pre 1,2; done 3,4.
    add(1, 1, 0, 3, 0, 0, 0, 0, 0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 5; c++) add(0, 1, 0, 0, 4'(c), c == 1 || c == 2, c >= 3, 1, c == 4);

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].s; en = vecs[i].e; mode = vecs[i].m; period = vecs[i].p;
      @(negedge clk);
      $display("vec %0d: start=%0b en=%0b period=%0d -> count=%0d pre=%0b done=%0b busy=%0b wrap=%0b",
               i, start, en, period, count, pre, done, busy, wrap);
      chk_all($sformatf("vec%0d", i), vecs[i].c, vecs[i].pr, vecs[i].dn, vecs[i].bz, vecs[i].wr);
      @(posedge clk);
      #1;
    end

    // Reset mid-period at count 4.
    start = 1'b1; en = 1'b1; period = 4'd0; mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_all("pre_rst", 4, 0, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    $display("reset mid-period: count=%0d pre=%0b done=%0b busy=%0b wrap=%0b", count, pre, done, busy, wrap);
    chk_all("post_rst", 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("idle_en", 0, 0, 0, 0, 0);

    // After reset a start with default period still gives a 10-count period.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    $display("after reset restart: count=%0d wrap=%0b", count, wrap);
    chk_all("rst_p9", 9, 0, 1, 1, 1);
`else
    // Prescaled: each count lasts 4 cycles, full default period is 40 cycles.
    start = 1'b1; en = 1'b1; period = 4'd0; mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      $display("presc cycle %0d: count=%0d wrap=%0b", k, count, wrap);
      chk($sformatf("presc%0d.count", k), int'(count), k / 4);
      chk($sformatf("presc%0d.wrap", k), int'(wrap), (k == 39) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk_all("presc_end", 0, 0, 0, 1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
